// File: rtl/flowid_pool_manager.sv
`default_nettype none
// =============================================================================
// flowid_pool_manager: circular free list of flowIDs (1..N-1) with allocation
// bitmap, two arbitrated release sources and a saturating error counter.
// Revision: 1.0
// =============================================================================
module flowid_pool_manager #(
  parameter int w_flowID  = 16,
  parameter int d_flowKTb = 3,
  parameter int w_errCnt  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pull_freeFlowID_enable,
  output logic [w_flowID-1:0]  free_flowID,
  output logic                 free_flowID_valid,
  input  logic                 conn_closed_valid,
  input  logic [w_flowID-1:0]  conn_closed_info,
  input  logic                 del_conn_valid,
  input  logic [w_flowID-1:0]  del_conn_info,
  output logic                 ready,
  output logic [d_flowKTb:0]   free_count,
  output logic [w_errCnt-1:0]  err_cnt
);

  localparam int C_N = 1 << d_flowKTb;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [w_flowID-1:0]  r_mem [C_N];
  logic [d_flowKTb-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [d_flowKTb-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [d_flowKTb-1:0] r_init_id, w_init_id_nxt;
  logic [C_N-1:0]       r_alloc, w_alloc_nxt;
  logic                 r_pend_valid, w_pend_valid_nxt;
  logic [w_flowID-1:0]  r_pend_id, w_pend_id_nxt;
  logic [d_flowKTb:0]   r_count, w_count_nxt;
  logic [w_errCnt-1:0]  r_err, w_err_nxt;
  logic [w_flowID-1:0]  r_head, w_head_nxt;
  logic [w_errCnt:0]    w_err_sum;

  logic                 w_wr_en;
  logic [w_flowID-1:0]  w_wr_data;
  logic                 w_pull_ok;
  logic                 w_cc_ok;
  logic                 w_del_ok;
  logic [1:0]           w_err_inc;

  // A release is acceptable only for an in-range, currently allocated ID.
  function automatic logic id_allocated(input logic [w_flowID-1:0] id,
                                        input logic [C_N-1:0]      alloc);
    if (id == '0 || (id >> d_flowKTb) != '0) return 1'b0;
    return alloc[id[d_flowKTb-1:0]];
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_init_id_nxt    = r_init_id;
    w_alloc_nxt      = r_alloc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_id_nxt    = r_pend_id;
    w_wr_en          = 1'b0;
    w_wr_data        = '0;
    w_pull_ok        = 1'b0;
    w_cc_ok          = 1'b0;
    w_del_ok         = 1'b0;
    w_err_inc        = '0;

    if (r_state == ST_INIT) begin
      w_err_inc     = 2'(pull_freeFlowID_enable) + 2'(conn_closed_valid) + 2'(del_conn_valid);
      w_init_id_nxt = r_init_id + 1'b1;
      if (r_init_id != '0) begin
        w_wr_en   = 1'b1;
        w_wr_data = w_flowID'(r_init_id);
        if (r_init_id == '1) w_state_nxt = ST_RUN;
      end
    end else begin
      w_pull_ok = pull_freeFlowID_enable && (r_count != '0);
      w_cc_ok   = conn_closed_valid && id_allocated(conn_closed_info, r_alloc);
      // Same ID on both sources in one cycle: only conn_closed may free it.
      w_del_ok  = del_conn_valid && id_allocated(del_conn_info, r_alloc) &&
                  !(w_cc_ok && del_conn_info == conn_closed_info);

      w_err_inc = 2'(pull_freeFlowID_enable && !w_pull_ok)
                + 2'(conn_closed_valid && !w_cc_ok)
                + 2'(del_conn_valid && (!w_del_ok || r_pend_valid));

      if (w_cc_ok) begin
        w_wr_en   = 1'b1;
        w_wr_data = conn_closed_info;
        w_alloc_nxt[conn_closed_info[d_flowKTb-1:0]] = 1'b0;
        if (w_del_ok && !r_pend_valid) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_id_nxt    = del_conn_info;
          w_alloc_nxt[del_conn_info[d_flowKTb-1:0]] = 1'b0;
        end
      end else if (r_pend_valid) begin
        w_wr_en          = 1'b1;
        w_wr_data        = r_pend_id;
        w_pend_valid_nxt = 1'b0;
      end else if (w_del_ok) begin
        w_wr_en   = 1'b1;
        w_wr_data = del_conn_info;
        w_alloc_nxt[del_conn_info[d_flowKTb-1:0]] = 1'b0;
      end

      if (w_pull_ok) begin
        w_alloc_nxt[r_head[d_flowKTb-1:0]] = 1'b1;
        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      end
    end

    w_alloc_nxt[0] = 1'b0;
    w_wr_ptr_nxt   = w_wr_en ? r_wr_ptr + 1'b1 : r_wr_ptr;
    w_count_nxt    = r_count + (d_flowKTb+1)'(w_wr_en) - (d_flowKTb+1)'(w_pull_ok);

    w_err_sum = {1'b0, r_err} + (w_errCnt+1)'(w_err_inc);
    w_err_nxt = w_err_sum[w_errCnt] ? '1 : w_err_sum[w_errCnt-1:0];

    // Show-ahead head; bypass the write when it lands in the head slot.
    w_head_nxt = '0;
    if (w_state_nxt == ST_RUN && w_count_nxt != '0) begin
      w_head_nxt = (w_wr_en && r_wr_ptr == w_rd_ptr_nxt) ? w_wr_data : r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_init_id    <= '0;
      r_alloc      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= '0;
      r_count      <= '0;
      r_err        <= '0;
      r_head       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_init_id    <= w_init_id_nxt;
      r_alloc      <= w_alloc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_id    <= w_pend_id_nxt;
      r_count      <= w_count_nxt;
      r_err        <= w_err_nxt;
      r_head       <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  assign free_flowID       = r_head;
  assign free_flowID_valid = (r_state == ST_RUN) && (r_count != '0);
  assign ready             = (r_state == ST_RUN) && !r_pend_valid;
  assign free_count        = r_count;
  assign err_cnt           = r_err;

endmodule
`default_nettype wire
